// File: rtl/mult_div_unit.sv
// mult_div_unit -- MIPS-style HI/LO multiply/divide unit.
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous active-high reset
//   start      request strobe, accepted only while idle
//   op[2:0]    0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6/7 ignored
//   operand_a  rs: dividend / multiplicand / MTHI-MTLO source
//   operand_b  rt: divisor / multiplier
//   busy       high while an iterative operation is in flight (registered)
//   done       one-cycle pulse after a MULT/DIV result lands in hi/lo (registered)
//   hi, lo     HI/LO result registers
//
// Configuration macro MULT_ITERATIVE_EN:
//   undefined -> MULT/MULTU use a single-cycle multiplier (result on the
//                accepting edge, no busy)
//   defined   -> MULT/MULTU run 32 shift-add steps with the same timing as
//                DIV/DIVU
// Divides always use a 32-step restoring divider on magnitudes, followed by
// a sign fixup in FINISH.
module mult_div_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] operand_a,
  input  logic [31:0] operand_b,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] RUN    = 2'd1;
  localparam logic [1:0] FINISH = 2'd2;

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  logic [1:0]  state;
  logic [5:0]  cnt;
  // Shared datapath: for divide acc=partial remainder, q=dividend shifting
  // out / quotient shifting in, d=divisor. For iterative multiply acc=upper
  // product, q=multiplier shifting out / lower product shifting in,
  // d=multiplicand.
  logic [31:0] acc_r, q_r, d_r;
  logic [31:0] a_r;        // raw dividend, returned in hi on divide-by-zero
  logic        is_div, div_zero, neg_q, neg_r;

  // Operand decode at acceptance
  logic        sgn;
  logic [31:0] mag_a, mag_b;
  always_comb begin
    sgn   = (op == OP_MULT) || (op == OP_DIV);
    mag_a = (sgn && operand_a[31]) ? (32'd0 - operand_a) : operand_a;
    mag_b = (sgn && operand_b[31]) ? (32'd0 - operand_b) : operand_b;
  end

`ifndef MULT_ITERATIVE_EN
  // Single-cycle product: extend per signedness, the low 64 bits of the
  // 64x64 product are the exact two's-complement result.
  logic [63:0] ax, bx, prod;
  always_comb begin
    ax   = {{32{sgn & operand_a[31]}}, operand_a};
    bx   = {{32{sgn & operand_b[31]}}, operand_b};
    prod = ax * bx;
  end
`endif

  // One iteration step (divide or multiply)
  logic [32:0] rem_sh, sum;
  logic [31:0] acc_n, q_n;
  always_comb begin
    rem_sh = {acc_r, q_r[31]};
    sum    = {1'b0, acc_r} + (q_r[0] ? {1'b0, d_r} : 33'd0);
    acc_n  = acc_r;
    q_n    = q_r;
    if (is_div) begin
      // rem_sh < 2*d, so a successful subtract always fits in 32 bits
      if (rem_sh >= {1'b0, d_r}) begin
        acc_n = rem_sh[31:0] - d_r;
        q_n   = {q_r[30:0], 1'b1};
      end else begin
        acc_n = rem_sh[31:0];
        q_n   = {q_r[30:0], 1'b0};
      end
    end else begin
      acc_n = sum[32:1];
      q_n   = {sum[0], q_r[31:1]};
    end
  end

  // Sign fixup for FINISH
  logic [63:0] prod_mag, prod_fix;
  logic [31:0] quo_fix, rem_fix;
  always_comb begin
    prod_mag = {acc_r, q_r};
    prod_fix = neg_q ? (64'd0 - prod_mag) : prod_mag;
    quo_fix  = neg_q ? (32'd0 - q_r) : q_r;
    rem_fix  = neg_r ? (32'd0 - acc_r) : acc_r;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= 6'd0;
      busy     <= 1'b0;
      done     <= 1'b0;
      hi       <= 32'd0;
      lo       <= 32'd0;
      acc_r    <= 32'd0;
      q_r      <= 32'd0;
      d_r      <= 32'd0;
      a_r      <= 32'd0;
      is_div   <= 1'b0;
      div_zero <= 1'b0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            case (op)
              OP_MULT, OP_MULTU: begin
`ifdef MULT_ITERATIVE_EN
                acc_r  <= 32'd0;
                q_r    <= mag_b;
                d_r    <= mag_a;
                is_div <= 1'b0;
                neg_q  <= sgn & (operand_a[31] ^ operand_b[31]);
                cnt    <= 6'd0;
                busy   <= 1'b1;
                state  <= RUN;
`else
                hi   <= prod[63:32];
                lo   <= prod[31:0];
                done <= 1'b1;
`endif
              end
              OP_DIV, OP_DIVU: begin
                acc_r    <= 32'd0;
                q_r      <= mag_a;
                d_r      <= mag_b;
                a_r      <= operand_a;
                is_div   <= 1'b1;
                div_zero <= (operand_b == 32'd0);
                neg_q    <= sgn & (operand_a[31] ^ operand_b[31]);
                neg_r    <= sgn & operand_a[31];
                cnt      <= 6'd0;
                busy     <= 1'b1;
                state    <= RUN;
              end
              OP_MTHI: hi <= operand_a;
              OP_MTLO: lo <= operand_a;
              default: ;
            endcase
          end
        end
        RUN: begin
          acc_r <= acc_n;
          q_r   <= q_n;
          if (cnt == 6'd31) begin
            cnt   <= 6'd0;
            state <= FINISH;
          end else begin
            cnt <= cnt + 6'd1;
          end
        end
        FINISH: begin
          if (!is_div) begin
            hi <= prod_fix[63:32];
            lo <= prod_fix[31:0];
          end else if (div_zero) begin
            hi <= a_r;
            lo <= 32'hFFFF_FFFF;
          end else begin
            hi <= rem_fix;
            lo <= quo_fix;
          end
          busy  <= 1'b0;
          done  <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/mult_div_unit.md
MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 The block SHALL have one clock and one reset; reset is asynchronous and active-high.
REQ-002 clk  input  1  clock; all state changes on rising edge.
REQ-003 reset  input  1  asynchronous active-high reset.
REQ-004 start  input  1  request strobe; sampled on the rising edge of clk.
REQ-005 op  input  3  operation: 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO; 6 and 7 reserved.
REQ-006 operand_a  input  32  rs value (dividend or multiplicand; MTHI/MTLO source).
REQ-007 operand_b  input  32  rt value (divisor or multiplier).
REQ-008 busy  output  1  high while an iterative operation is in flight.
REQ-009 done  output  1  one-cycle pulse when MULT/MULTU/DIV/DIVU results land in hi/lo.
REQ-010 hi  output  32  HI register (product upper word or remainder).
REQ-011 lo  output  32  LO register (product lower word or quotient).

Function
REQ-012 States SHALL be IDLE, RUN and FINISH; start is accepted only in IDLE.
REQ-013 Start with busy=1 SHALL be ignored, with no effect on state, hi or lo.
REQ-014 Start with op=6 or op=7 SHALL be ignored.
REQ-015 MTHI/MTLO SHALL write operand_a to hi/lo on the accepting edge, with no busy and no done.
REQ-016 DIV/DIVU accepted at edge E SHALL load operands, then go IDLE->RUN.
REQ-017 RUN SHALL execute one restoring-division step per cycle for 32 cycles on 32-bit magnitudes, with a 6-bit iteration counter.
REQ-018 After the 32nd step the block SHALL enter FINISH, apply the sign fixup, write hi/lo and return to IDLE.
REQ-019 For DIV/DIVU, busy SHALL be high from after edge E until edge E+33.
REQ-020 For DIV/DIVU, hi/lo SHALL update at edge E+33, and done SHALL be high for exactly the cycle following edge E+33.
REQ-021 Signed divide: quotient truncates toward zero; remainder takes the sign of the dividend.
REQ-022 Divide by zero: lo=0xFFFFFFFF and hi=operand_a, for both DIV and DIVU, with normal latency.
REQ-023 DIV with 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0.
REQ-024 MULT/MULTU SHALL produce the full 64-bit product, {hi,lo}; MULT is two's-complement signed, MULTU unsigned.
REQ-025 Operands SHALL be captured at acceptance; operand changes while busy SHALL NOT affect the result.
REQ-026 hi/lo SHALL hold their value between writes; a result SHALL NOT partially update hi/lo before FINISH.
REQ-027 done and busy SHALL be registered outputs, and done SHALL never be high in the same cycle as busy.

Reset
REQ-028 Reset SHALL asynchronously force state IDLE, busy=0, done=0, hi=0, lo=0 and counter=0.
REQ-029 Reset mid-operation SHALL abandon the operation with no later done and no hi/lo write.
REQ-030 The first start SHALL be accepted on the first rising edge after reset deasserts.

Configuration
REQ-031 Macro MULT_ITERATIVE_EN SHALL select the multiplier implementation.
REQ-032 Undefined: MULT/MULTU use a single-cycle multiplier; hi/lo update on the accepting edge E, done is high in the cycle after E, and busy stays 0.
REQ-033 Defined: MULT/MULTU use 32-cycle shift-add through RUN/FINISH, with timing identical to REQ-019/020.
REQ-034 Results SHALL be bit-identical in both configurations.

Verification
REQ-035 Unsigned divide: DIVU 100/7 -> busy for 33 cycles, then done pulse, lo=14, hi=2.
REQ-036 Signed divide with negative dividend: DIV -7/2 (0xFFFFFFF9/2) -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
REQ-037 Divide by zero: DIVU 0x1234/0 -> lo=0xFFFFFFFF, hi=0x00001234.
REQ-038 Signed multiply (both macro settings): MULT 0xFFFFFFFF*2 -> hi=0xFFFFFFFF, lo=0xFFFFFFFE.
REQ-039 Signed multiply overflow boundary (both macro settings): MULT 0x80000000*0x80000000 -> hi=0x40000000, lo=0.
REQ-040 Start while busy and MTHI: start DIVU 9/3, a second start at cycle 5 is ignored, and after done lo=3, hi=0; then MTHI 0xDEADBEEF gives hi=0xDEADBEEF next cycle with no done.
REQ-041 Reset mid-divide: assert reset at cycle 10 of a DIV -> busy=0, hi=lo=0 immediately, and no done follows.
